// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants, FSM state encoding and checksum helper for the UART
// command controller.
package uart_cmd_ctrl_pkg;

  localparam int FRAME_LEN = 5;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_CLEAR = 8'h43;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CHK  = 3'd2,
    ST_EXEC = 3'd3,
    ST_TX   = 3'd4
  } state_t;

  function automatic logic [7:0] xor4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return a ^ b ^ c ^ d;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bus between the command controller (master) and the UART frame buffers (slave).
interface uart_cmd_ctrl_if;

  // full is a level: a new frame is offered on its 0->1 edge only. r_data
  // answers `address` one clock later. we qualifies address/w_data in the
  // same cycle; the UART never back-pressures, so there is no ready.
  logic       full;
  logic [7:0] r_data;
  logic [2:0] address;
  logic       we;
  logic [7:0] w_data;

  modport master (
    input  full,
    input  r_data,
    output address,
    output we,
    output w_data
  );

  modport slave (
    output full,
    output r_data,
    input  address,
    input  we,
    input  w_data
  );

endinterface

// File: rtl/cmd_regfile.sv
// Command-addressable register file: one write port, one read mux, a
// synchronous clear-all, and a flat view of every register.
module cmd_regfile #(
  parameter  int NUM_REGS = 4,
  parameter  int REG_W    = 16,
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we_i,
  input  logic [IDX_W-1:0]          waddr_i,
  input  logic [REG_W-1:0]          wdata_i,
  input  logic                      clr_i,
  input  logic [IDX_W-1:0]          raddr_i,
  output logic [REG_W-1:0]          rdata_o,
  output logic [NUM_REGS*REG_W-1:0] regs_o
);

  logic [REG_W-1:0] regs_q [NUM_REGS];

  // Clear wins over write; the controller never requests both at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[i*REG_W +: REG_W] = regs_q[i];
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Reads a 5-byte command frame from the UART receive buffer, executes it
// against the register file, and writes a 5-byte ACK/NAK frame back.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  uart_cmd_ctrl_if.master           uart,
  output logic [NUM_REGS*REG_W-1:0] regs_out,
  output logic                      busy,
  output logic [7:0]                err_cnt,
  output logic                      ovr,
  output state_t                    dbg_state
);

  localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [2:0] RD_LAST = 3'(FRAME_LEN);
  localparam logic [2:0] TX_LAST = 3'(FRAME_LEN - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       full_q;
  logic [7:0] rx_q [FRAME_LEN];
  logic       err_q;
  logic [7:0] err_cnt_q;
  logic       ovr_q;

  logic       full_rise;
  logic [7:0] rx_op, rx_idx, rx_dlo, rx_dhi, rx_chk;
  logic       op_known, idx_bad, frame_err;
  logic       reg_we, reg_clr;
  logic [REG_W-1:0] wr_data, rd_data;
  logic [15:0] rsp_data;
  logic [7:0] rsp [FRAME_LEN];

  assign full_rise = uart.full & ~full_q;

  assign rx_op  = rx_q[0];
  assign rx_idx = rx_q[1];
  assign rx_dlo = rx_q[2];
  assign rx_dhi = rx_q[3];
  assign rx_chk = rx_q[4];

  // Index range only matters for opcodes that address a register.
  assign op_known  = (rx_op == OP_WRITE) || (rx_op == OP_READ) || (rx_op == OP_CLEAR);
  assign idx_bad   = ((rx_op == OP_WRITE) || (rx_op == OP_READ)) &&
                     (32'(rx_idx) >= 32'(NUM_REGS));
  assign frame_err = (rx_chk != xor4(rx_op, rx_idx, rx_dlo, rx_dhi)) || !op_known || idx_bad;

  assign reg_we  = (state_q == ST_EXEC) && !err_q && (rx_op == OP_WRITE);
  assign reg_clr = (state_q == ST_EXEC) && !err_q && (rx_op == OP_CLEAR);
  assign wr_data = REG_W'({rx_dhi, rx_dlo});

  cmd_regfile #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (reg_we),
    .waddr_i (rx_idx[IDX_W-1:0]),
    .wdata_i (wr_data),
    .clr_i   (reg_clr),
    .raddr_i (rx_idx[IDX_W-1:0]),
    .rdata_o (rd_data),
    .regs_o  (regs_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      full_q    <= 1'b1;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      ovr_q     <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) rx_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= uart.full;
      // Read latency is one cycle, so RD cycle k captures the byte for address k-1.
      if ((state_q == ST_RD) && (cnt_q != 3'd0)) rx_q[cnt_q - 3'd1] <= uart.r_data;
      if (state_q == ST_CHK) err_q <= frame_err;
      if ((state_q == ST_EXEC) && err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      if (full_rise && (state_q != ST_IDLE)) ovr_q <= 1'b1;
      else if (reg_clr)                      ovr_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (full_rise) begin
          state_d = ST_RD;
          cnt_d   = '0;
        end
      end
      ST_RD: begin
        if (cnt_q == RD_LAST) begin
          state_d = ST_CHK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_CHK:  state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_TX;
        cnt_d   = '0;
      end
      ST_TX: begin
        if (cnt_q == TX_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registers already hold the post-EXEC value during TX, so ACK reads them directly.
  always_comb begin
    rsp_data = (rx_op == OP_CLEAR) ? 16'h0000 : 16'(rd_data);
    rsp[0]   = err_q ? RSP_NAK : RSP_ACK;
    rsp[1]   = err_q ? rx_op   : rx_idx;
    rsp[2]   = err_q ? 8'h00   : rsp_data[7:0];
    rsp[3]   = err_q ? 8'h00   : rsp_data[15:8];
    rsp[4]   = xor4(rsp[0], rsp[1], rsp[2], rsp[3]);
  end

  always_comb begin
    uart.address = '0;
    uart.we      = 1'b0;
    uart.w_data  = '0;
    if ((state_q == ST_RD) && (cnt_q < RD_LAST)) begin
      uart.address = cnt_q;
    end else if (state_q == ST_TX) begin
      uart.address = cnt_q;
      uart.we      = 1'b1;
      uart.w_data  = rsp[cnt_q];
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign err_cnt   = err_cnt_q;
  assign ovr       = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: a driver loads frames into a UART
// receive-buffer model, a negedge monitor scores every transmit byte.
module tb_uart_cmd_ctrl;
  import uart_cmd_ctrl_pkg::*;

  localparam int NUM_REGS = 4;
  localparam int REG_W    = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_ctrl_if uart();

  logic [NUM_REGS*REG_W-1:0] regs_out;
  logic                      busy;
  logic [7:0]                err_cnt;
  logic                      ovr;
  state_t                    dbg_state;

  uart_cmd_ctrl #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart      (uart),
    .regs_out  (regs_out),
    .busy      (busy),
    .err_cnt   (err_cnt),
    .ovr       (ovr),
    .dbg_state (dbg_state)
  );

  // UART receive buffer: registered read, one cycle of latency.
  logic [7:0] rx_mem [8];
  always @(posedge clk) uart.r_data <= rx_mem[uart.address];

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_cmp    = 0;
  int n_fail   = 0;
  int we_total = 0;
  int mon_pos  = 0;
  int edge_cyc = 0;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pos = 0;
    end else if (uart.we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_we: got byte 0x%0h, expected no write", uart.w_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", 64'(uart.w_data), 64'(mon_exp));
        check("tx_address", 64'(uart.address), 64'(mon_pos));
        if (mon_pos == 0) check("tx_latency", 64'(cyc - edge_cyc), 64'd8);
      end
      we_total++;
      mon_pos = (mon_pos == 4) ? 0 : mon_pos + 1;
    end else if (mon_pos != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL we_gap: got we low after %0d bytes, expected 5 consecutive", mon_pos);
      mon_pos = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 60);
    if (busy || exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, expected idle", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Frames are written MSB-first: byte 0 in bits [39:32].
  task automatic send_frame(input logic [39:0] frm, input logic [39:0] rsp,
                            input bit pulse_in_tx, input bit hold_full);
    int we_start;
    int n;
    for (int i = 0; i < 5; i++) begin
      rx_mem[i] = frm[39-8*i -: 8];
      exp_q.push_back(rsp[39-8*i -: 8]);
    end
    we_start = we_total;
    @(negedge clk);
    uart.full = 1'b1;
    @(posedge clk);
    #1 edge_cyc = cyc;
    if (!hold_full) begin
      @(negedge clk);
      uart.full = 1'b0;
    end
    if (pulse_in_tx) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!uart.we && n < 30);
      uart.full = 1'b1;
      @(negedge clk);
      uart.full = 1'b0;
    end
    wait_idle();
    if (hold_full) begin
      repeat (10) @(negedge clk);
      uart.full = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("we_count", 64'(we_total - we_start), 64'd5);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},    64'(busy),         64'd0);
    check({pfx, "_we"},      64'(uart.we),      64'd0);
    check({pfx, "_address"}, 64'(uart.address), 64'd0);
    check({pfx, "_w_data"},  64'(uart.w_data),  64'd0);
    check({pfx, "_err_cnt"}, 64'(err_cnt),      64'd0);
    check({pfx, "_ovr"},     64'(ovr),          64'd0);
    check({pfx, "_regs"},    64'(regs_out),     64'd0);
    check({pfx, "_state"},   64'(dbg_state),    64'(ST_IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    int n;
    int k;
    uart.full = 1'b0;
    for (int i = 0; i < 8; i++) rx_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write reg2, then read it back with full held high (no retrigger).
    send_frame(40'h57_02_34_12_73, 40'h06_02_34_12_22, 1'b0, 1'b0);
    check("regs_after_write", 64'(regs_out), 64'h0000_1234_0000_0000);
    send_frame(40'h52_02_00_00_50, 40'h06_02_34_12_22, 1'b0, 1'b1);
    check("regs_after_read", 64'(regs_out), 64'h0000_1234_0000_0000);
    check("ovr_after_read", 64'(ovr), 64'd0);

    // Bad checksum.
    send_frame(40'h57_01_AA_BB_00, 40'h15_57_00_00_42, 1'b0, 1'b0);
    check("err_cnt_bad_chk", 64'(err_cnt), 64'd1);
    check("reg1_bad_chk", 64'(regs_out[31:16]), 64'd0);

    // Bad index, with a second frame offered while transmitting.
    send_frame(40'h57_04_00_00_53, 40'h15_57_00_00_42, 1'b1, 1'b0);
    base = we_total;
    repeat (20) @(negedge clk);
    check("no_second_response", 64'(we_total - base), 64'd0);
    check("ovr_set", 64'(ovr), 64'd1);
    check("err_cnt_bad_idx", 64'(err_cnt), 64'd2);
    check("regs_after_bad_idx", 64'(regs_out), 64'h0000_1234_0000_0000);

    // Reset on the third transmit byte, full high across release.
    rx_mem[0] = 8'h57; rx_mem[1] = 8'h00; rx_mem[2] = 8'hCD; rx_mem[3] = 8'hAB; rx_mem[4] = 8'h31;
    exp_q.push_back(8'h06); exp_q.push_back(8'h00); exp_q.push_back(8'hCD);
    exp_q.push_back(8'hAB); exp_q.push_back(8'h60);
    @(negedge clk);
    uart.full = 1'b1;
    @(posedge clk);
    #1 edge_cyc = cyc;
    @(negedge clk);
    uart.full = 1'b0;
    n = 0;
    k = 0;
    while (n < 3 && k < 40) begin
      @(negedge clk);
      k++;
      if (uart.we) n++;
    end
    check("third_we_seen", 64'(n), 64'd3);
    #1;
    rst_n     = 1'b0;
    uart.full = 1'b1;
    #1;
    check_reset_outputs("mid_tx_rst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base  = we_total;
    repeat (20) @(negedge clk);
    check("no_resp_after_rst", 64'(we_total - base), 64'd0);
    check("idle_after_rst", 64'(busy), 64'd0);
    uart.full = 1'b0;
    repeat (3) @(negedge clk);

    // Populate reg3, saturate err_cnt, set ovr on the last bad frame, then clear.
    send_frame(40'h57_03_EF_BE_05, 40'h06_03_EF_BE_54, 1'b0, 1'b0);
    check("regs_reg3", 64'(regs_out), 64'hBEEF_0000_0000_0000);
    for (int i = 0; i < 256; i++) begin
      send_frame(40'h57_01_AA_BB_00, 40'h15_57_00_00_42, (i == 255), 1'b0);
      if (i == 254) check("err_cnt_reach_255", 64'(err_cnt), 64'd255);
    end
    repeat (20) @(negedge clk);
    check("err_cnt_saturated", 64'(err_cnt), 64'd255);
    check("ovr_before_clear", 64'(ovr), 64'd1);
    check("regs_before_clear", 64'(regs_out), 64'hBEEF_0000_0000_0000);
    send_frame(40'h43_00_00_00_43, 40'h06_00_00_00_06, 1'b0, 1'b0);
    check("regs_after_clear", 64'(regs_out), 64'd0);
    check("ovr_after_clear", 64'(ovr), 64'd0);
    check("err_cnt_after_clear", 64'(err_cnt), 64'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
